alu_seq: RTL and testbench

Execute-stage sequencer for the shared 32-bit integer ALU.
- Accepts one decoded operation (one-hot ALU code plus two operands) over a valid/ready handshake.
- Runs it: single-cycle for arithmetic/logic/compare, iterative one-bit-per-cycle for shifts.
- Presents the result on a valid/ready output port.
- Sits between the ALU decode stage and writeback; it is the only master of the ALU datapath.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq_alu32.sv | 40 ++++
 rtl/alu_seq.sv | 127 ++++++++++++
 tb/tb_alu_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, op bit indices and sequencer state enum
package alu_pkg;

  localparam int XLEN     = 32;
  localparam int OP_WIDTH = 10;
  localparam int SHAMT_W  = 5;

  // Bit positions inside the one-hot op code
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_SLT  = 8;
  localparam int ALU_SLTU = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // Exactly one bit set; zero and multi-hot codes are illegal
  function automatic logic is_onehot(logic [OP_WIDTH-1:0] op);
    return (op != '0) && ((op & (op - OP_WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result handshake bundle between decode, alu_seq and writeback
interface alu_seq_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OP_WIDTH-1:0] in_op;
  logic [XLEN-1:0]     in_a;
  logic [XLEN-1:0]     in_b;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_result;
  logic                out_err;
  logic                busy;

  // Upstream/downstream side: issues ops and consumes results
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_err, busy
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_err, busy
  );

endinterface

// File: rtl/alu_seq_alu32.sv
// rtl/alu_seq_alu32.sv - combinational single-cycle ALU datapath (shifts included when ALU_SEQ_BARREL_EN)
module alu32
  import alu_pkg::*;
(
  input  logic [OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     result,
  output logic                err
);

`ifdef ALU_SEQ_BARREL_EN
  logic [SHAMT_W-1:0] shamt;
  assign shamt = b[SHAMT_W-1:0];
`endif

  // Select the result of the single op named by the one-hot code; illegal codes give 0
  always_comb begin
    result = '0;
    err    = !is_onehot(op);
    if (!err) begin
      case (1'b1)
        op[ALU_ADD]:  result = a + b;
        op[ALU_SUB]:  result = a - b;
        op[ALU_AND]:  result = a & b;
        op[ALU_OR]:   result = a | b;
        op[ALU_XOR]:  result = a ^ b;
        op[ALU_SLT]:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        op[ALU_SLTU]: result = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef ALU_SEQ_BARREL_EN
        op[ALU_SLL]:  result = a << shamt;
        op[ALU_SRL]:  result = a >> shamt;
        op[ALU_SRA]:  result = XLEN'($signed(a) >>> shamt);
`endif
        default:      result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execute-stage ALU sequencer, iterative shifts unless ALU_SEQ_BARREL_EN
module alu_seq
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  alu_seq_if.slave  bus
);

  alu_state_t      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_err;

`ifndef ALU_SEQ_BARREL_EN
  logic [XLEN-1:0]    shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  // Shift kind kept as {sra, srl, sll} so the SHIFT state needs no full op
  logic [2:0]         shop_q, shop_d;
  logic [XLEN-1:0]    shreg_next;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_is_shift;

  assign in_shamt    = bus.in_b[SHAMT_W-1:0];
  assign in_is_shift = (|bus.in_op[ALU_SRA:ALU_SLL]) & ~alu_err;

  // One-bit step of the iterative shifter
  always_comb begin
    shreg_next = shreg_q;
    if (shop_q[0])      shreg_next = {shreg_q[XLEN-2:0], 1'b0};
    else if (shop_q[1]) shreg_next = {1'b0, shreg_q[XLEN-1:1]};
    else                shreg_next = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
  end

  assign bus.busy = (state_q == ST_SHIFT);
`else
  assign bus.busy = 1'b0;
`endif

  // DONE accepts a new op in the same cycle its result is taken
  assign bus.in_ready   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_result = result_q;
  assign bus.out_err    = err_q;

  alu32 u_alu32 (
    .op     (bus.in_op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .result (alu_res),
    .err    (alu_err)
  );

  // Next-state and datapath: advance shifts, retire results, load accepted ops
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
`ifndef ALU_SEQ_BARREL_EN
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    shop_d   = shop_q;
`endif
    case (state_q)
      ST_IDLE: ;
`ifndef ALU_SEQ_BARREL_EN
      ST_SHIFT: begin
        shreg_d = shreg_next;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shreg_next;
          err_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // in_ready already restricts this to IDLE or a consumed DONE
    if (accept) begin
      state_d  = ST_DONE;
      result_d = alu_res;
      err_d    = alu_err;
`ifndef ALU_SEQ_BARREL_EN
      shop_d   = bus.in_op[ALU_SRA:ALU_SLL];
      if (in_is_shift) begin
        if (in_shamt == '0) begin
          result_d = bus.in_a;
        end else begin
          shreg_d = bus.in_a;
          cnt_d   = in_shamt;
          state_d = ST_SHIFT;
        end
      end
`endif
    end
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
`ifndef ALU_SEQ_BARREL_EN
      shreg_q  <= '0;
      cnt_q    <= '0;
      shop_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifndef ALU_SEQ_BARREL_EN
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      shop_q   <= shop_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq, directed cases then random traffic
module tb_alu_seq;
  import alu_pkg::*;

`ifdef ALU_SEQ_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if bus ();

  alu_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          acc;
    int          lat;
    int          nbusy;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  bit   mon_en = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the op means, plus how long it should take
  function automatic exp_t model(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh;
    int   k;
    sh = int'(b % 32);
    e.res = 0; e.err = 1'b0; e.acc = 0; e.lat = 1; e.nbusy = 0;
    if ($countones(op) != 1) begin
      e.err = 1'b1;
      return e;
    end
    k = 0;
    for (int i = 0; i < 10; i++) if (op[i]) k = i;
    case (k)
      0: e.res = a + b;
      1: e.res = a - b;
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = a ^ b;
      5: e.res = a << sh;
      6: e.res = a >> sh;
      7: e.res = 32'($signed(a) >>> sh);
      8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = (a < b) ? 32'd1 : 32'd0;
    endcase
    if (k >= 5 && k <= 7 && !BARREL && sh != 0) begin
      e.lat   = sh + 1;
      e.nbusy = sh;
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the rising edge that accepted
  task automatic send(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    bit   done;
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_a = a; bus.in_b = b;
    t = 0; done = 1'b0;
    while (!done && t < 300) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = model(op, a, b);
        e.acc = cyc;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready never high for op 0x%03h", op);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
    end
  endtask

  // Monitor: compare every presented result against the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy) busy_cnt = busy_cnt + 1;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: result 0x%08h with nothing outstanding", bus.out_result);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc), 32'(sb[0].acc + sb[0].lat));
            seen = 1'b1;
          end
          chk("result", bus.out_result, sb[0].res);
          chk("err", 32'(bus.out_err), 32'(sb[0].err));
          if (bus.out_ready) begin
            chk("busy_cycles", 32'(busy_cnt), 32'(sb[0].nbusy));
            void'(sb.pop_front());
            seen = 1'b0;
            busy_cnt = 0;
          end
        end
      end
    end
  end

  // Random backpressure when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  op;
    logic [31:0] a, b;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_err", 32'(bus.out_err), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Reset mid-shift: sll 1 by 20, reset applied while shifting
    bus.in_valid = 1'b1; bus.in_op = 10'b1 << ALU_SLL; bus.in_a = 32'd1; bus.in_b = 32'd20;
    @(negedge clk);
    chk("mid_accept", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.busy), BARREL ? 32'd0 : 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_out_result", bus.out_result, 0);
    @(posedge clk); #1;

    mon_en = 1'b1;
    bus.out_ready = 1'b1;

    // Back-to-back single-cycle ops
    send(10'b1 << ALU_ADD, 32'd7, 32'd5);
    send(10'b1 << ALU_SUB, 32'd3, 32'd5);
    send(10'b1 << ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    send(10'b1 << ALU_SLTU, 32'hFFFF_FFFF, 32'd1);

    // Shifts, including shamt 0 with upper B bits set and the 31-bit extreme
    send(10'b1 << ALU_SRA, 32'h8000_0000, 32'd4);
    send(10'b1 << ALU_SRL, 32'h8000_0000, 32'd4);
    send(10'b1 << ALU_SLL, 32'h1234_5678, 32'h0000_0020);
    send(10'b1 << ALU_SLL, 32'd1, 32'd31);
    wait_drain();

    // Backpressure hold
    bus.out_ready = 1'b0;
    send(10'b1 << ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_valid", 32'(bus.out_valid), 0);
    chk("bp_idle_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Illegal code followed by a legal op
    send(10'b00_0000_0011, 32'd5, 32'd6);
    send(10'b1 << ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    send(10'b0, 32'd1, 32'd2);
    wait_drain();

    // Random traffic with random gaps and backpressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 9) == 0) begin
        op = 10'($urandom);
        if ($countones(op) == 1) op = '0;
      end else begin
        op = 10'b1 << $urandom_range(0, 9);
      end
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send(op, a, b);
    end
    wait_drain();
    rdy_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
